csi2rx_raw10_b2p: RTL and testbench

- Receive-side byte-to-pixel unpacker for CSI-2 RAW10 / YUV420-10b payloads. Inverse of the TX 10-bit pixel packer.
- Takes 32-bit payload dwords from the packet decoder, after header strip and ECC/CRC. Emits groups of four 10-bit pixels with a valid/ready handshake.
- Output goes to the pixel interface. Input is back-pressured whenever the byte accumulator cannot absorb another dword.

---
 rtl/csi2rx_raw10_b2p_pkg.sv | 29 ++
 rtl/csi2rx_raw10_grp_unpack.sv | 18 +
 rtl/csi2rx_raw10_b2p.sv | 251 +++++++++++++++++++++++++
 tb/tb_csi2rx_raw10_b2p.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2rx_raw10_b2p_pkg.sv
// Shared definitions for the CSI-2 RX RAW10 / YUV420-10b byte-to-pixel path:
// state encodings, group geometry, RAW10 data-type code and a byte-mask helper.
package csi2rx_raw10_b2p_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } b2p_state_e;

    localparam int         RAW10_GRP_BYTES = 5;
    localparam int         RAW10_GRP_PIX   = 4;
    localparam int         RAW10_GRP_BITS  = 40;
    localparam logic [5:0] DT_RAW10        = 6'h2B;

    // Keeps the low nbytes bytes of a payload dword; the rest become zero padding.
    function automatic logic [31:0] dw_byte_mask(input logic [2:0] nbytes);
        logic [31:0] mask;
        case (nbytes)
            3'd0:    mask = 32'h0000_0000;
            3'd1:    mask = 32'h0000_00FF;
            3'd2:    mask = 32'h0000_FFFF;
            3'd3:    mask = 32'h00FF_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/csi2rx_raw10_grp_unpack.sv
// Combinational RAW10 group unpacker: five payload bytes in, four 10-bit pixels out.
// Shared with the YUV420-10b path, which uses the same 5-byte packing.
module csi2rx_raw10_grp_unpack
    import csi2rx_raw10_b2p_pkg::*;
(
    input  logic [39:0] grp_i,
    output logic [39:0] pix_o
);

    // Pixel k takes byte k as its eight MSBs and two LSBs from the shared fifth byte.
    always_comb begin
        pix_o = 40'd0;
        for (int k = 0; k < RAW10_GRP_PIX; k++) begin
            pix_o[k*10 +: 10] = {grp_i[k*8 +: 8], grp_i[32 + 2*k +: 2]};
        end
    end

endmodule

// File: rtl/csi2rx_raw10_b2p.sv
// CSI-2 RX RAW10 byte-to-pixel unpacker: 32-bit payload dwords in, 4-pixel groups out.
// Optional build macro CSI2RX_B2P_ERR_CNT_EN adds a saturating wc_err counter.
module csi2rx_raw10_b2p
    import csi2rx_raw10_b2p_pkg::*;
#(
    parameter int WC_W      = 16,
    parameter int ACC_BYTES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pkt_sop_i,
    input  logic [WC_W-1:0] pkt_wc_i,
    input  logic [31:0]     dw_i,
    input  logic            dw_vld_i,
    output logic            dw_rdy_o,
    output logic [39:0]     pix_data_o,
    output logic            pix_vld_o,
    input  logic            pix_rdy_i,
    output logic            pix_eop_o,
    output logic            wc_err_o
`ifdef CSI2RX_B2P_ERR_CNT_EN
    ,
    input  logic            err_cnt_clr_i,
    output logic [7:0]      err_cnt_o
`endif
);

    localparam int         ACC_W    = ACC_BYTES * 8;
    localparam logic [3:0] GRP_FILL = 4'(RAW10_GRP_BYTES);

    b2p_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       fill_q, fill_d;
    logic [WC_W-1:0]  bl_q, bl_d;
    logic [39:0]      pix_data_q, pix_data_d;
    logic             pix_vld_q, pix_vld_d;
    logic             pix_eop_q, pix_eop_d;
    logic             wc_err_q, wc_err_d;

    logic             out_free_s, abort_s, wc_nz_s, wc_odd_s;
    logic             pop_old_s, pop_new_s, dw_rdy_s, accept_s;
    logic [3:0]       fill_ap_s, fill_in_s, fill_nx_s;
    logic [ACC_W-1:0] acc_ap_s, acc_in_s, acc_nx_s;
    logic [2:0]       take_s;
    logic [WC_W-1:0]  bl_in_s;
    logic [39:0]      grp_src_s, grp_pix_s;

    // Accumulator arithmetic: retire a complete group first, then append the accepted
    // dword; a group completed by this dword is popped now so it shows one clock later.
    always_comb begin
        out_free_s = !pix_vld_q || pix_rdy_i;
        abort_s    = pkt_sop_i && (state_q != ST_IDLE);
        wc_nz_s    = (pkt_wc_i != {WC_W{1'b0}});
        wc_odd_s   = ((pkt_wc_i % WC_W'(RAW10_GRP_BYTES)) != {WC_W{1'b0}});
        pop_old_s  = (state_q == ST_ACTIVE) && (fill_q >= GRP_FILL) && out_free_s;
        if (pop_old_s) begin
            fill_ap_s = fill_q - GRP_FILL;
            acc_ap_s  = acc_q >> RAW10_GRP_BITS;
        end else begin
            fill_ap_s = fill_q;
            acc_ap_s  = acc_q;
        end
        if (bl_q >= WC_W'(4)) begin
            take_s = 3'd4;
        end else begin
            take_s = bl_q[2:0];
        end
        dw_rdy_s = (state_q == ST_ACTIVE) && (bl_q != {WC_W{1'b0}}) && (fill_ap_s <= 4'd4);
        accept_s = dw_rdy_s && dw_vld_i;
        if (accept_s) begin
            acc_in_s  = acc_ap_s | (ACC_W'(dw_i & dw_byte_mask(take_s)) << {fill_ap_s, 3'b000});
            fill_in_s = fill_ap_s + {1'b0, take_s};
            bl_in_s   = bl_q - WC_W'(take_s);
        end else begin
            acc_in_s  = acc_ap_s;
            fill_in_s = fill_ap_s;
            bl_in_s   = bl_q;
        end
        pop_new_s = (state_q == ST_ACTIVE) && !pop_old_s && (fill_in_s >= GRP_FILL) && out_free_s;
        if (pop_new_s) begin
            grp_src_s = acc_in_s[39:0];
            acc_nx_s  = acc_in_s >> RAW10_GRP_BITS;
            fill_nx_s = fill_in_s - GRP_FILL;
        end else begin
            grp_src_s = acc_q[39:0];
            acc_nx_s  = acc_in_s;
            fill_nx_s = fill_in_s;
        end
    end

    csi2rx_raw10_grp_unpack u_unpack (
        .grp_i (grp_src_s),
        .pix_o (grp_pix_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a new sop outside IDLE restarts the packet.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pkt_sop_i && wc_nz_s) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (abort_s) begin
                    state_d = wc_nz_s ? ST_ACTIVE : ST_IDLE;
                end else if ((bl_in_s == {WC_W{1'b0}}) && (fill_nx_s < GRP_FILL)) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_FLUSH: begin
                if (abort_s) begin
                    state_d = wc_nz_s ? ST_ACTIVE : ST_IDLE;
                end else if ((fill_q == 4'd0) || out_free_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: accumulator, byte budget, output register and error pulse.
    always_comb begin
        acc_d      = acc_q;
        fill_d     = fill_q;
        bl_d       = bl_q;
        pix_data_d = pix_data_q;
        pix_vld_d  = pix_vld_q && !pix_rdy_i;
        pix_eop_d  = pix_eop_q;
        wc_err_d   = 1'b0;
        if (abort_s) begin
            acc_d      = {ACC_W{1'b0}};
            fill_d     = 4'd0;
            bl_d       = pkt_wc_i;
            pix_data_d = 40'd0;
            pix_vld_d  = 1'b0;
            pix_eop_d  = 1'b0;
            wc_err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pkt_sop_i) begin
                        bl_d     = pkt_wc_i;
                        wc_err_d = wc_nz_s && wc_odd_s;
                    end else begin
                        bl_d     = bl_q;
                    end
                end
                ST_ACTIVE: begin
                    acc_d  = acc_nx_s;
                    fill_d = fill_nx_s;
                    bl_d   = bl_in_s;
                    if (pop_old_s || pop_new_s) begin
                        pix_data_d = grp_pix_s;
                        pix_vld_d  = 1'b1;
                        pix_eop_d  = (bl_in_s == {WC_W{1'b0}}) && (fill_nx_s == 4'd0);
                    end else begin
                        pix_data_d = pix_data_q;
                    end
                end
                ST_FLUSH: begin
                    // Upper accumulator bytes are always zero, so the tail is already padded.
                    if ((fill_q != 4'd0) && out_free_s) begin
                        acc_d      = {ACC_W{1'b0}};
                        fill_d     = 4'd0;
                        pix_data_d = grp_pix_s;
                        pix_vld_d  = 1'b1;
                        pix_eop_d  = 1'b1;
                        wc_err_d   = 1'b1;
                    end else begin
                        acc_d      = acc_q;
                    end
                end
                default: begin
                    acc_d  = {ACC_W{1'b0}};
                    fill_d = 4'd0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= {ACC_W{1'b0}};
            fill_q     <= 4'd0;
            bl_q       <= {WC_W{1'b0}};
            pix_data_q <= 40'd0;
            pix_vld_q  <= 1'b0;
            pix_eop_q  <= 1'b0;
            wc_err_q   <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            bl_q       <= bl_d;
            pix_data_q <= pix_data_d;
            pix_vld_q  <= pix_vld_d;
            pix_eop_q  <= pix_eop_d;
            wc_err_q   <= wc_err_d;
        end
    end

    assign dw_rdy_o   = dw_rdy_s;
    assign pix_data_o = pix_data_q;
    assign pix_vld_o  = pix_vld_q;
    assign pix_eop_o  = pix_eop_q;
    assign wc_err_o   = wc_err_q;

`ifdef CSI2RX_B2P_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Error counter next value: clear wins, increment saturates at 255.
    always_comb begin
        if (err_cnt_clr_i) begin
            err_cnt_d = 8'd0;
        end else if (wc_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_csi2rx_raw10_b2p.sv
// Scoreboard bench for csi2rx_raw10_b2p: expected groups are queued as packets are
// driven and compared by a monitor as the pixel handshake completes.
module tb_csi2rx_raw10_b2p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pkt_sop_i;
    logic [15:0] pkt_wc_i;
    logic [31:0] dw_i;
    logic        dw_vld_i;
    logic        dw_rdy_o;
    logic [39:0] pix_data_o;
    logic        pix_vld_o;
    logic        pix_rdy_i;
    logic        pix_eop_o;
    logic        wc_err_o;
`ifdef CSI2RX_B2P_ERR_CNT_EN
    logic        err_cnt_clr_i;
    logic [7:0]  err_cnt_o;
`endif

    int errors   = 0;
    int checks   = 0;
    int err_seen = 0;
    int err_base = 0;
    int cyc      = 0;
    int cur_wc   = 0;
    logic [7:0]  pb [64];
    logic [40:0] exp_q [$];
    logic [40:0] mon_e;

    csi2rx_raw10_b2p #(.WC_W(16), .ACC_BYTES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pkt_sop_i  (pkt_sop_i),
        .pkt_wc_i   (pkt_wc_i),
        .dw_i       (dw_i),
        .dw_vld_i   (dw_vld_i),
        .dw_rdy_o   (dw_rdy_o),
        .pix_data_o (pix_data_o),
        .pix_vld_o  (pix_vld_o),
        .pix_rdy_i  (pix_rdy_i),
        .pix_eop_o  (pix_eop_o),
        .wc_err_o   (wc_err_o)
`ifdef CSI2RX_B2P_ERR_CNT_EN
        ,
        .err_cnt_clr_i (err_cnt_clr_i),
        .err_cnt_o     (err_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wc_err_o) err_seen++;
            if (pix_vld_o && pix_rdy_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL group_unexpected: got eop=%b data=%h, required no group", pix_eop_o, pix_data_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({pix_eop_o, pix_data_o} !== mon_e) begin
                        errors++;
                        $display("FAIL group: got eop=%b data=%h, required eop=%b data=%h",
                                 pix_eop_o, pix_data_o, mon_e[40], mon_e[39:0]);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [39:0] grp(input int base);
        logic [7:0] b [5];
        for (int i = 0; i < 5; i++) b[i] = (base + i < cur_wc) ? pb[base + i] : 8'h00;
        return {b[3], b[4][7:6], b[2], b[4][5:4], b[1], b[4][3:2], b[0], b[4][1:0]};
    endfunction

    function automatic logic [31:0] dword(input int k);
        return {pb[4*k+3], pb[4*k+2], pb[4*k+1], pb[4*k]};
    endfunction

    task automatic fill_pkt(input int wc);
        for (int i = 0; i < 64; i++) pb[i] = 8'($urandom);
        cur_wc = wc;
    endtask

    task automatic push_groups();
        for (int b = 0; b < cur_wc; b += 5) exp_q.push_back({(b + 5 >= cur_wc), grp(b)});
    endtask

    task automatic start_pkt(input logic [15:0] wc);
        pkt_sop_i = 1'b1;
        pkt_wc_i  = wc;
        @(posedge clk); #1;
        pkt_sop_i = 1'b0;
    endtask

    task automatic send_dw(input logic [31:0] d);
        bit got = 0;
        dw_i     = d;
        dw_vld_i = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (dw_rdy_o) got = 1;
            @(posedge clk); #1;
        end
        dw_vld_i = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL dw_accept: dword %h got accepted=0, required 1", d);
        end
    endtask

    task automatic send_packet(input int wc);
        fill_pkt(wc);
        push_groups();
        start_pkt(16'(wc));
        for (int k = 0; k < (wc + 3) / 4; k++) send_dw(dword(k));
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d groups outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (pix_data_o !== 40'd0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 0", pix_data_o);
        end
        checks++;
        if ({pix_vld_o, pix_eop_o, wc_err_o, dw_rdy_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got vld/eop/err/rdy=%b, required 0000",
                     {pix_vld_o, pix_eop_o, wc_err_o, dw_rdy_o});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_group();
        int e0 = err_seen;
        pix_rdy_i = 1'b1;
        exp_q.push_back({1'b1, 10'h103, 10'h0C2, 10'h081, 10'h040});
        start_pkt(16'd5);
        send_dw(32'h4030_2010);
        send_dw(32'hA5A5_A5E4);
        @(negedge clk);
        checks++;
        if (pix_vld_o !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: pix_vld got %b one clock after last byte, required 1", pix_vld_o);
        end
        drain("single");
        checks++;
        if (err_seen - e0 != 0) begin
            errors++;
            $display("FAIL single_wc_err: got %0d pulses, required 0", err_seen - e0);
        end
    endtask

    task automatic test_steady_stream();
        int t0, t1;
        pix_rdy_i = 1'b1;
        fill_pkt(20);
        push_groups();
        start_pkt(16'd20);
        t0 = cyc;
        for (int k = 0; k < 5; k++) send_dw(dword(k));
        t1 = cyc;
        checks++;
        if (t1 - t0 > 6) begin
            errors++;
            $display("FAIL steady_rate: 5 dwords took %0d cycles, required at most 6", t1 - t0);
        end
        drain("steady");
    endtask

    task automatic test_backpressure();
        int k = 0;
        logic [39:0] held;
        pix_rdy_i = 1'b0;
        fill_pkt(20);
        push_groups();
        start_pkt(16'd20);
        for (int c = 0; c < 10; c++) begin
            dw_i     = dword(k);
            dw_vld_i = (k < 5);
            @(negedge clk);
            if (c == 5) held = pix_data_o;
            if (c == 9) begin
                checks++;
                if (dw_rdy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_dw_rdy: got %b while stalled, required 0", dw_rdy_o);
                end
                checks++;
                if (pix_data_o !== held) begin
                    errors++;
                    $display("FAIL bp_hold: pix_data got %h, required %h", pix_data_o, held);
                end
            end
            if (dw_vld_i && dw_rdy_o) k++;
            @(posedge clk); #1;
        end
        dw_vld_i = 1'b0;
        // One group parks in the output register, which frees room for a third dword.
        checks++;
        if (k != 3) begin
            errors++;
            $display("FAIL bp_accepted: got %0d dwords while stalled, required 3", k);
        end
        pix_rdy_i = 1'b1;
        for (int j = k; j < 5; j++) send_dw(dword(j));
        drain("backpressure");
    endtask

    task automatic test_short_payload();
        int e0 = err_seen;
        pix_rdy_i = 1'b1;
        send_packet(7);
        drain("short");
        checks++;
        if (err_seen - e0 != 2) begin
            errors++;
            $display("FAIL short_wc_err: got %0d pulses, required 2", err_seen - e0);
        end
    endtask

    task automatic test_zero_wc();
        int e0 = err_seen;
        bit bad = 0;
        start_pkt(16'd0);
        repeat (4) begin
            @(negedge clk);
            if (dw_rdy_o !== 1'b0 || pix_vld_o !== 1'b0) bad = 1;
        end
        checks++;
        if (bad || err_seen != e0) begin
            errors++;
            $display("FAIL zero_wc: got activity=%0d wc_err=%0d, required 0 and 0", bad, err_seen - e0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int e0 = err_seen;
        pix_rdy_i = 1'b0;
        fill_pkt(20);
        start_pkt(16'd20);
        send_dw(dword(0));
        send_dw(dword(1));
        fill_pkt(10);
        push_groups();
        start_pkt(16'd10);
        checks++;
        if (pix_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: pix_vld got %b after abort, required 0", pix_vld_o);
        end
        pix_rdy_i = 1'b1;
        for (int k = 0; k < 3; k++) send_dw(dword(k));
        drain("abort");
        checks++;
        if (err_seen - e0 != 1) begin
            errors++;
            $display("FAIL abort_wc_err: got %0d pulses, required 1", err_seen - e0);
        end
    endtask

    task automatic test_reset_mid_packet();
        pix_rdy_i = 1'b1;
        fill_pkt(20);
        exp_q.push_back({1'b0, grp(0)});
        start_pkt(16'd20);
        send_dw(dword(0));
        send_dw(dword(1));
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({pix_vld_o, dw_rdy_o} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_async: got vld/rdy=%b, required 00", {pix_vld_o, dw_rdy_o});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        err_base = err_seen;
        @(negedge clk);
        checks++;
        if ({pix_vld_o, dw_rdy_o} !== 2'b00 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_idle: got vld/rdy=%b pending=%0d, required 00 and 0",
                     {pix_vld_o, dw_rdy_o}, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
        send_packet(15);
        drain("rst_mid_next");
    endtask

`ifdef CSI2RX_B2P_ERR_CNT_EN
    task automatic test_err_cnt();
        send_packet(7);
        drain("err_cnt_pkt");
        checks++;
        if (int'(err_cnt_o) != err_seen - err_base) begin
            errors++;
            $display("FAIL err_cnt: got %0d, required %0d", err_cnt_o, err_seen - err_base);
        end
        err_cnt_clr_i = 1'b1;
        @(posedge clk); #1;
        err_cnt_clr_i = 1'b0;
        checks++;
        if (err_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL err_cnt_clr: got %0d, required 0", err_cnt_o);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        pkt_sop_i = 1'b0;
        pkt_wc_i  = 16'd0;
        dw_i      = 32'd0;
        dw_vld_i  = 1'b0;
        pix_rdy_i = 1'b1;
`ifdef CSI2RX_B2P_ERR_CNT_EN
        err_cnt_clr_i = 1'b0;
`endif
        test_reset();
        test_single_group();
        test_steady_stream();
        test_backpressure();
        test_short_payload();
        test_zero_wc();
        test_abort();
        test_reset_mid_packet();
`ifdef CSI2RX_B2P_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
